ring_osc_counter: RTL and testbench



---
 rtl/ring_meas_pkg.sv | 21 ++
 rtl/sync_rise_detect.sv | 40 ++++
 rtl/ring_osc_counter.sv | 103 ++++++++++
 tb/tb_ring_osc_counter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ring_meas_pkg.sv
// Shared types and defaults for ring-oscillator measurement blocks.
// State encoding, default widths and drain-length helper.
package ring_meas_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } meas_state_t;

  localparam int COUNT_W_DEF     = 32;
  localparam int TIME_W_DEF      = 32;
  localparam int SYNC_STAGES_DEF = 2;

  // Edges still in flight need the synchroniser depth plus the pulse register.
  function automatic int drain_len(int sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Multi-flop synchroniser with a registered rising-edge pulse.
// clear wipes the edge history so a new window starts clean.
module sync_rise_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              prev;
  logic              s;

  assign s = sync[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else if (clear) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      prev <= s;
      rise <= s & ~prev;
    end
  end

endmodule

// File: rtl/ring_osc_counter.sv
// Gates an adder ring loop for a fixed window and counts its edges.
// Window FSM plus saturating edge counter.
module ring_osc_counter
  import ring_meas_pkg::*;
#(
  parameter int COUNT_W     = COUNT_W_DEF,
  parameter int TIME_W      = TIME_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               wb_clk_i,
  input  logic               reset,
  input  logic               start,
  input  logic [TIME_W-1:0]  time_limit,
  input  logic               chain_out,
  output logic               ring_en,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] count,
  output logic               overflow
);

  localparam logic [TIME_W-1:0] DRAIN_CYC =
    TIME_W'(drain_len(SYNC_STAGES));
  localparam logic [TIME_W-1:0] ONE = TIME_W'(1);

  meas_state_t       state;
  meas_state_t       nstate;
  logic [TIME_W-1:0] win;
  logic              go;
  logic              rise;
  logic              counting;

  sync_rise_detect #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (wb_clk_i),
    .rst  (reset),
    .clear(go),
    .din  (chain_out),
    .rise (rise)
  );

  assign go       = start & (state == IDLE || state == DONE);
  assign counting = (state == RUN) || (state == DRAIN);
  assign ring_en  = (state == RUN);
  assign busy     = counting;
  assign done     = (state == DONE);

  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          nstate = (time_limit != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (win == ONE) nstate = DRAIN;
      end
      DRAIN: begin
        if (win == ONE) nstate = DONE;
      end
    endcase
  end

  // One down-counter times both the window and the drain tail.
  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      win <= '0;
    end else if (go) begin
      win <= time_limit;
    end else if (state == RUN) begin
      win <= (win == ONE) ? DRAIN_CYC : win - ONE;
    end else if (state == DRAIN) begin
      win <= win - ONE;
    end
  end

  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (go) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (counting && rise) begin
      if (&count) begin
        overflow <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ring_osc_counter.sv
// Scoreboard bench for ring_osc_counter.
// Edge counts come from the driven chain pattern, not the DUT.
module tb_ring_osc_counter;

  localparam int CW   = 4;
  localparam int TW   = 8;
  localparam int SS   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          wb_clk_i = 1'b0;
  logic          reset;
  logic          start;
  logic [TW-1:0] time_limit;
  logic          chain_out;
  logic          ring_en;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;
  logic          overflow;

  typedef struct {
    int cnt;
    int ovf;
    int en_n;
    int busy_n;
  } exp_t;

  exp_t sb[$];
  bit   pat[$];
  int   passed = 0;
  int   total  = 0;

  ring_osc_counter #(
    .COUNT_W    (CW),
    .TIME_W     (TW),
    .SYNC_STAGES(SS)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .reset     (reset),
    .start     (start),
    .time_limit(time_limit),
    .chain_out (chain_out),
    .ring_en   (ring_en),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  // Ring model: plays the queued pattern while enabled, idles low otherwise.
  initial begin
    chain_out = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      if (ring_en === 1'b1 && pat.size() > 0) chain_out = pat.pop_front();
      else chain_out = 1'b0;
    end
  end

  // Monitor: on each rising done, compare against the oldest expectation.
  initial begin
    int   en_n;
    int   busy_n;
    logic done_q;
    exp_t e;
    en_n = 0;
    busy_n = 0;
    done_q = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      if (reset !== 1'b0) begin
        en_n = 0;
        busy_n = 0;
        done_q = 1'b0;
      end else begin
        if (ring_en === 1'b1) en_n++;
        if (busy === 1'b1) busy_n++;
        if (done === 1'b1 && done_q !== 1'b1) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("count", 32'(count), e.cnt);
            chk("overflow", 32'(overflow), e.ovf);
            chk("ring_en_cycles", en_n, e.en_n);
            chk("busy_cycles", busy_n, e.busy_n);
          end
          en_n = 0;
          busy_n = 0;
        end
        done_q = done;
      end
    end
  end

  // kind 0: toggle every clock starting from 0; kind 1: random levels.
  task automatic prep(int t, int kind);
    bit   prev;
    bit   v;
    int   edges;
    exp_t x;
    prev  = 1'b0;
    edges = 0;
    for (int i = 0; i < t; i++) begin
      v = (kind == 0) ? (i % 2 == 0) : 1'($urandom);
      pat.push_back(v);
      if (v && !prev) edges++;
      prev = v;
    end
    x.cnt    = (edges > MAXC) ? MAXC : edges;
    x.ovf    = (edges > MAXC) ? 1 : 0;
    x.en_n   = t;
    x.busy_n = (t == 0) ? 0 : t + SS + 1;
    sb.push_back(x);
  endtask

  task automatic launch(int t, int kind);
    prep(t, kind);
    start = 1'b1;
    time_limit = TW'(t);
    @(negedge wb_clk_i);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (done !== 1'b1) begin
      chk("done_timeout", 0, 1);
      sb.delete();
      pat.delete();
    end
    repeat (2) @(negedge wb_clk_i);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    time_limit = '0;
    repeat (3) @(negedge wb_clk_i);
    chk("rst_ring_en", 32'(ring_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    reset = 1'b0;
    repeat (2) @(negedge wb_clk_i);

    // Basic 10-cycle window with a toggling ring.
    launch(10, 0);
    wait_done();

    // Reset in the middle of a long window.
    for (int i = 0; i < 100; i++) pat.push_back(i % 2 == 0);
    start = 1'b1;
    time_limit = TW'(100);
    @(negedge wb_clk_i);
    start = 1'b0;
    repeat (19) @(posedge wb_clk_i);
    #2 reset = 1'b1;
    #1;
    chk("midrun_ring_en", 32'(ring_en), 0);
    chk("midrun_busy", 32'(busy), 0);
    chk("midrun_done", 32'(done), 0);
    chk("midrun_count", 32'(count), 0);
    pat.delete();
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    reset = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_done", 32'(done), 0);
    chk("post_rst_ring_en", 32'(ring_en), 0);

    // Zero-length window straight from IDLE.
    launch(0, 0);
    chk("zero_done", 32'(done), 1);
    chk("zero_ring_en", 32'(ring_en), 0);
    chk("zero_count", 32'(count), 0);
    wait_done();

    // Saturation, then a short window clears it.
    launch(40, 0);
    wait_done();
    launch(4, 0);
    wait_done();

    // start held through RUN and time_limit changed mid-window.
    prep(10, 0);
    start = 1'b1;
    time_limit = TW'(10);
    @(negedge wb_clk_i);
    repeat (4) @(negedge wb_clk_i);
    time_limit = TW'(3);
    repeat (5) @(negedge wb_clk_i);
    start = 1'b0;
    wait_done();
    launch(3, 0);
    wait_done();

    // Random windows and random ring levels.
    for (int k = 0; k < 12; k++) begin
      launch(int'($urandom_range(1, 40)), 1);
      wait_done();
    end

    repeat (4) @(negedge wb_clk_i);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
